// File: rtl/counter_pkg.sv
// Shared definitions for the up/down event/tick counter family.
//   DIR_UP / DIR_DN       : encoding of the dir input
//   MODE_WRAP / MODE_SAT  : values of the SAT parameter
//   phase_width()         : register width needed for a prescaler phase
//                           counting 0..PRESCALE-1 (never less than 1 bit)
package counter_pkg;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic int phase_width(input int prescale);
    int w;
    w = $clog2(prescale);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/prescale_tick.sv
// Enable prescaler: emits one tick for every PRESCALE qualified en cycles.
//   clk     : system clock, posedge
//   rstn    : asynchronous active-low reset, phase returns to 0
//   en      : qualifying enable; low cycles hold the phase
//   restart : synchronous phase clear (driven by clr | load)
//   tick    : en & (phase == PRESCALE-1), combinational
module prescale_tick
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int            PW      = phase_width(PRESCALE);
  localparam logic [PW-1:0] PH_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase_d, phase_q;

  // With PRESCALE=1 the phase never leaves 0, so tick collapses to en.
  assign tick = en & (phase_q == PH_LAST);

  always_comb begin
    phase_d = phase_q;
    if (restart) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = tick ? '0 : phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// General-purpose modulo up/down counter with prescaled enable.
// Counts 0..MAX, wrapping (SAT=0) or saturating (SAT=1) at the ends.
//   clk      : system clock, posedge
//   rstn     : asynchronous active-low reset
//   clr      : synchronous clear of count, prescaler phase and ovf
//   load     : synchronous load of load_val (clamped to MAX)
//   load_val : value to load
//   en       : count enable, feeds the prescaler
//   dir      : 0 = up, 1 = down, sampled on the step cycle
//   out      : registered count
//   tc       : one-cycle pulse aligned with the count after a boundary step
//   ovf      : sticky boundary flag, cleared only by clr or reset
// Edge priority: clr > load > step.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX      = 2**N - 1,
  parameter int PRESCALE = 1,
  parameter int SAT      = MODE_WRAP
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  input  logic         dir,
  output logic [N-1:0] out,
  output logic         tc,
  output logic         ovf
);

  localparam logic [N-1:0] MAX_V = N'(MAX);

  logic         step;
  logic         at_bound;
  logic [N-1:0] cnt_d, cnt_q;
  logic         tc_d, tc_q;
  logic         ovf_d, ovf_q;

  prescale_tick #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .restart (clr | load),
    .tick    (step)
  );

  assign at_bound = (dir == DIR_UP) ? (cnt_q == MAX_V) : (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      // Clamp so out can never leave 0..MAX, even right after a load.
      cnt_d = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (step) begin
      if (at_bound) begin
        // In saturate mode every attempt at the boundary still counts as an event.
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (SAT == MODE_SAT) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = (dir == DIR_UP) ? '0 : MAX_V;
        end
      end else begin
        cnt_d = (dir == DIR_UP) ? cnt_q + N'(1) : cnt_q - N'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign out = cnt_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench: three counters (wrap, saturate, prescale-by-3) share one stimulus
// stream; each is compared every cycle with an arithmetic reference model.
module tb_mod_updown_counter;

  localparam int NB = 4;
  localparam int NI = 3;
  localparam int MAX_W = 9, PRE_W = 1, SAT_W = 0;
  localparam int MAX_S = 9, PRE_S = 1, SAT_S = 1;
  localparam int MAX_P = 9, PRE_P = 3, SAT_P = 0;

  int max_v [NI] = '{MAX_W, MAX_S, MAX_P};
  int pre_v [NI] = '{PRE_W, PRE_S, PRE_P};
  int sat_v [NI] = '{SAT_W, SAT_S, SAT_P};
  string nm [NI] = '{"wrap", "sat", "pre3"};

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic clr = 1'b0, load = 1'b0, en = 1'b0, dir = 1'b0;
  logic [NB-1:0] load_val = '0;

  logic [NB-1:0] dut_out [NI];
  logic          dut_tc  [NI];
  logic          dut_ovf [NI];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_cnt [NI];
  int m_ph  [NI];
  int m_tc  [NI];
  int m_ovf [NI];

  always #5 clk = ~clk;

  mod_updown_counter #(.N(NB), .MAX(MAX_W), .PRESCALE(PRE_W), .SAT(SAT_W)) u_wrap (
    .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .dir(dir), .out(dut_out[0]), .tc(dut_tc[0]), .ovf(dut_ovf[0]));

  mod_updown_counter #(.N(NB), .MAX(MAX_S), .PRESCALE(PRE_S), .SAT(SAT_S)) u_sat (
    .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .dir(dir), .out(dut_out[1]), .tc(dut_tc[1]), .ovf(dut_ovf[1]));

  mod_updown_counter #(.N(NB), .MAX(MAX_P), .PRESCALE(PRE_P), .SAT(SAT_P)) u_pre (
    .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .dir(dir), .out(dut_out[2]), .tc(dut_tc[2]), .ovf(dut_ovf[2]));

  typedef struct {
    logic       c;
    logic       l;
    logic [3:0] lv;
    logic       e;
    logic       d;
    int         e_out;
    int         e_tc;
    int         e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NI; i++) begin
      m_cnt[i] = 0; m_ph[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
    end
  endfunction

  // One count step in plain integer arithmetic: go one past, then fold back
  // into 0..MAX if the result left the range.
  function automatic void model_take_step(input int i, input logic d);
    int nxt;
    nxt = d ? m_cnt[i] - 1 : m_cnt[i] + 1;
    if (nxt < 0 || nxt > max_v[i]) begin
      m_tc[i]  = 1;
      m_ovf[i] = 1;
      if (sat_v[i] != 0) nxt = m_cnt[i];
      else               nxt = (nxt < 0) ? max_v[i] : 0;
    end
    m_cnt[i] = nxt;
  endfunction

  function automatic void model_edge(input logic c, input logic l, input logic [3:0] lv,
                                     input logic e, input logic d);
    for (int i = 0; i < NI; i++) begin
      m_tc[i] = 0;
      if (c) begin
        m_cnt[i] = 0; m_ph[i] = 0; m_ovf[i] = 0;
      end else if (l) begin
        m_cnt[i] = (int'(lv) > max_v[i]) ? max_v[i] : int'(lv);
        m_ph[i]  = 0;
      end else if (e) begin
        m_ph[i]++;
        if (m_ph[i] == pre_v[i]) begin
          m_ph[i] = 0;
          model_take_step(i, d);
        end
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s/%s out", tag, nm[i]), int'(dut_out[i]), m_cnt[i]);
      check($sformatf("%s/%s tc",  tag, nm[i]), int'(dut_tc[i]),  m_tc[i]);
      check($sformatf("%s/%s ovf", tag, nm[i]), int'(dut_ovf[i]), m_ovf[i]);
    end
  endtask

  // Drive inputs away from the edge, take one posedge, advance the model,
  // then settle 1 time unit so outputs are sampled clear of the edge.
  task automatic apply(input logic c, input logic l, input logic [3:0] lv,
                       input logic e, input logic d);
    clr = c; load = l; load_val = lv; en = e; dir = d;
    @(posedge clk);
    model_edge(c, l, lv, e, d);
    #1;
  endtask

  task automatic expect_one(input string tag, input int i, input int eo, input int et, input int ev);
    check($sformatf("%s/%s out", tag, nm[i]), int'(dut_out[i]), eo);
    check($sformatf("%s/%s tc",  tag, nm[i]), int'(dut_tc[i]),  et);
    check($sformatf("%s/%s ovf", tag, nm[i]), int'(dut_ovf[i]), ev);
  endtask

  function automatic void add(input logic c, input logic l, input logic [3:0] lv,
                              input logic e, input logic d, input int eo, input int et, input int ev);
    vec_t v;
    v.c = c; v.l = l; v.lv = lv; v.e = e; v.d = d;
    v.e_out = eo; v.e_tc = et; v.e_ovf = ev;
    vecs.push_back(v);
  endfunction

  initial begin
    // wrap counter, MAX=9: count up through the boundary
    for (int k = 1; k <= 9; k++) add(0, 0, 4'd0, 1, 0, k, 0, 0);
    add(0, 0, 4'd0, 1, 0, 0, 1, 1);
    add(0, 0, 4'd0, 1, 0, 1, 0, 1);
    add(0, 0, 4'd0, 1, 0, 2, 0, 1);
    // clear, load 0, one step down wraps to MAX, clear again
    add(1, 0, 4'd0, 0, 0, 0, 0, 0);
    add(0, 1, 4'd0, 0, 0, 0, 0, 0);
    add(0, 0, 4'd0, 1, 1, 9, 1, 1);
    add(1, 0, 4'd0, 0, 0, 0, 0, 0);
    // clamped load, then step up wraps from MAX
    add(0, 1, 4'd15, 1, 0, 9, 0, 0);
    add(0, 0, 4'd0, 1, 0, 0, 1, 1);
    add(0, 0, 4'd0, 0, 1, 0, 0, 1);

    model_reset();
    #1 rstn = 1'b0;
    #2;
    compare_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    foreach (vecs[k]) begin
      apply(vecs[k].c, vecs[k].l, vecs[k].lv, vecs[k].e, vecs[k].d);
      expect_one($sformatf("vec%0d", k), 0, vecs[k].e_out, vecs[k].e_tc, vecs[k].e_ovf);
      compare_all($sformatf("vec%0d", k));
    end

    // saturate: load 8, up x3, down x2
    apply(1, 0, 4'd0, 0, 0);
    apply(0, 1, 4'd8, 0, 0);
    apply(0, 0, 4'd0, 1, 0); expect_one("sat_up1", 1, 9, 0, 0);
    apply(0, 0, 4'd0, 1, 0); expect_one("sat_up2", 1, 9, 1, 1);
    apply(0, 0, 4'd0, 1, 0); expect_one("sat_up3", 1, 9, 1, 1);
    apply(0, 0, 4'd0, 1, 1); expect_one("sat_dn1", 1, 8, 0, 1);
    apply(0, 0, 4'd0, 1, 1); expect_one("sat_dn2", 1, 7, 0, 1);
    compare_all("sat_seq");

    // prescale-by-3 with en pattern 1,1,0,1,1,1,1
    apply(1, 0, 4'd0, 0, 0);
    begin
      logic pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      int   exp_o [7] = '{0, 0, 0, 1, 1, 1, 2};
      for (int k = 0; k < 7; k++) begin
        apply(0, 0, 4'd0, pat[k], 0);
        check($sformatf("pre_pat%0d out", k), int'(dut_out[2]), exp_o[k]);
        check($sformatf("pre_pat%0d tc", k), int'(dut_tc[2]), 0);
      end
    end
    compare_all("pre_seq");

    // clr beats load beats step, then a clamped load
    apply(1, 1, 4'd5, 1, 0);
    for (int i = 0; i < NI; i++) expect_one("clr_prio", i, 0, 0, 0);
    apply(0, 1, 4'd15, 0, 0);
    expect_one("clamp", 0, 9, 0, 0);
    compare_all("prio_seq");

    // async reset mid-count with prescaler phase at 1
    apply(1, 0, 4'd0, 0, 0);
    apply(0, 1, 4'd6, 0, 0);
    apply(0, 0, 4'd0, 1, 0);
    check("mid pre out", int'(dut_out[2]), 6);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < NI; i++) expect_one("async_rst", i, 0, 0, 0);
    #2 rstn = 1'b1;
    apply(0, 0, 4'd0, 1, 0); check("post_rst1 out", int'(dut_out[2]), 0);
    apply(0, 0, 4'd0, 1, 0); check("post_rst2 out", int'(dut_out[2]), 0);
    apply(0, 0, 4'd0, 1, 0); check("post_rst3 out", int'(dut_out[2]), 1);
    compare_all("rst_seq");

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(199) == 0) begin
        rstn = 1'b0;
        #2;
        model_reset();
        compare_all($sformatf("rnd%0d_rst", k));
        rstn = 1'b1;
      end else begin
        apply(logic'($urandom_range(39) == 0),
              logic'($urandom_range(19) == 0),
              4'($urandom_range(15)),
              logic'($urandom_range(9) < 7),
              logic'($urandom_range(1)));
        compare_all($sformatf("rnd%0d", k));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
